// File: rtl/decode_ctrl_pipe.sv
// rtl/decode_ctrl_pipe.sv - registered RV32IM decode/control stage with load-use and MDU stalls
// Optional perf counters are built when DECODE_CTRL_PERF_EN is defined.
module decode_ctrl_pipe #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MDU_LATENCY    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH-1:0]     Instr,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      flush,
   input  logic                      ex_mem_read,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      RegWrite,
   output logic                      MemWrite,
   output logic                      MemRead,
   output logic                      Branch,
   output logic                      Jump,
   output logic                      JumpReg,
   output logic                      ALUSel,
   output logic                      ALUSrcA,
   output logic                      IsMDU,
   output logic                      illegal,
   output logic [1:0]                ResultSel,
   output logic [3:0]                ALUCtrl,
   output logic [2:0]                ImmSel,
   output logic [2:0]                funct3_o,
   output logic [REG_ADDR_WIDTH-1:0] rs1,
   output logic [REG_ADDR_WIDTH-1:0] rs2,
   output logic [REG_ADDR_WIDTH-1:0] rd,
   output logic                      mdu_start
`ifdef DECODE_CTRL_PERF_EN
   ,
   output logic [31:0]               perf_stall_cnt,
   output logic [31:0]               perf_mdu_cnt
`endif
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam int CNT_W = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;

   typedef struct packed {
      logic                      reg_write;
      logic                      mem_write;
      logic                      mem_read;
      logic                      branch;
      logic                      jump;
      logic                      jump_reg;
      logic                      alu_sel;
      logic                      alu_src_a;
      logic                      is_mdu;
      logic                      illegal;
      logic [1:0]                result_sel;
      logic [3:0]                alu_ctrl;
      logic [2:0]                imm_sel;
      logic [2:0]                funct3;
      logic [REG_ADDR_WIDTH-1:0] rs1;
      logic [REG_ADDR_WIDTH-1:0] rs2;
      logic [REG_ADDR_WIDTH-1:0] rd;
   } ctrl_t;

   typedef enum logic {
      S_IDLE,
      S_MDU_WAIT
   } state_t;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   ctrl_t      dec;
   logic       uses_rs1;
   logic       uses_rs2;
   logic       luse;
   logic       accept;

   ctrl_t              ctrl_q, ctrl_d;
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic               mdu_start_q, mdu_start_d;

   assign opcode = Instr[6:0];
   assign funct3 = Instr[14:12];
   assign funct7 = Instr[31:25];

   always_comb begin
      dec        = '0;
      dec.funct3 = funct3;
      dec.rs1    = Instr[19:15];
      dec.rs2    = Instr[24:20];
      dec.rd     = Instr[11:7];
      case (opcode)
         OPC_LOAD: begin
            dec.reg_write  = 1'b1;
            dec.mem_read   = 1'b1;
            dec.alu_sel    = 1'b1;
            dec.result_sel = 2'b01;
         end
         OPC_STORE: begin
            dec.mem_write = 1'b1;
            dec.alu_sel   = 1'b1;
            dec.imm_sel   = 3'b001;
         end
         OPC_OP: begin
            if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
               dec.reg_write = 1'b1;
               dec.alu_ctrl  = {funct7[5] & (funct3 == 3'b000 || funct3 == 3'b101), funct3};
            end else if (funct7 == 7'b0000001) begin
               dec.reg_write = 1'b1;
               dec.is_mdu    = 1'b1;
               dec.alu_ctrl  = {1'b1, funct3};
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OPC_OPIMM: begin
            // only the arithmetic right shift borrows funct7[5]; ADDI stays an add
            dec.reg_write = 1'b1;
            dec.alu_sel   = 1'b1;
            dec.alu_ctrl  = {funct7[5] & (funct3 == 3'b101), funct3};
         end
         OPC_BRANCH: begin
            dec.branch   = 1'b1;
            dec.imm_sel  = 3'b010;
            dec.alu_ctrl = 4'b1000;
         end
         OPC_LUI: begin
            dec.reg_write  = 1'b1;
            dec.imm_sel    = 3'b011;
            dec.result_sel = 2'b10;
         end
         OPC_AUIPC: begin
            dec.reg_write = 1'b1;
            dec.alu_src_a = 1'b1;
            dec.alu_sel   = 1'b1;
            dec.imm_sel   = 3'b011;
         end
         OPC_JAL: begin
            dec.jump       = 1'b1;
            dec.reg_write  = 1'b1;
            dec.imm_sel    = 3'b100;
            dec.result_sel = 2'b11;
         end
         OPC_JALR: begin
            dec.jump_reg   = 1'b1;
            dec.reg_write  = 1'b1;
            dec.alu_sel    = 1'b1;
            dec.result_sel = 2'b11;
         end
         default: dec.illegal = 1'b1;
      endcase
      if (dec.rd == '0) begin
         dec.reg_write = 1'b0;
      end
   end

   always_comb begin
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      case (opcode)
         OPC_OP, OPC_STORE, OPC_BRANCH: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OPC_OPIMM, OPC_LOAD, OPC_JALR: uses_rs1 = 1'b1;
         default: ;
      endcase
   end

   assign luse = ex_mem_read && (ex_rd != '0) &&
                 ((uses_rs1 && ex_rd == Instr[19:15]) || (uses_rs2 && ex_rd == Instr[24:20]));

   assign in_ready = (!out_valid_q || out_ready) && (state_q == S_IDLE) && !luse && !flush;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      ctrl_d      = ctrl_q;
      mdu_start_d = 1'b0;
      if (flush) begin
         out_valid_d = 1'b0;
         state_d     = S_IDLE;
         cnt_d       = '0;
      end else begin
         if (state_q == S_MDU_WAIT) begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         if (accept) begin
            ctrl_d      = dec;
            out_valid_d = 1'b1;
            if (dec.is_mdu) begin
               mdu_start_d = 1'b1;
               if (MDU_LATENCY > 1) begin
                  state_d = S_MDU_WAIT;
                  cnt_d   = CNT_W'(MDU_LATENCY - 1);
               end
            end
         end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         mdu_start_q <= 1'b0;
         ctrl_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         mdu_start_q <= mdu_start_d;
         ctrl_q      <= ctrl_d;
      end
   end

   assign out_valid = out_valid_q;
   assign mdu_start = mdu_start_q;
   assign RegWrite  = ctrl_q.reg_write;
   assign MemWrite  = ctrl_q.mem_write;
   assign MemRead   = ctrl_q.mem_read;
   assign Branch    = ctrl_q.branch;
   assign Jump      = ctrl_q.jump;
   assign JumpReg   = ctrl_q.jump_reg;
   assign ALUSel    = ctrl_q.alu_sel;
   assign ALUSrcA   = ctrl_q.alu_src_a;
   assign IsMDU     = ctrl_q.is_mdu;
   assign illegal   = ctrl_q.illegal;
   assign ResultSel = ctrl_q.result_sel;
   assign ALUCtrl   = ctrl_q.alu_ctrl;
   assign ImmSel    = ctrl_q.imm_sel;
   assign funct3_o  = ctrl_q.funct3;
   assign rs1       = ctrl_q.rs1;
   assign rs2       = ctrl_q.rs2;
   assign rd        = ctrl_q.rd;

`ifdef DECODE_CTRL_PERF_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_mdu_q;

   // saturating counters; flush deliberately does not clear them
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_mdu_q   <= '0;
      end else begin
         if (in_valid && !in_ready && perf_stall_q != 32'hFFFF_FFFF) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if (mdu_start_q && perf_mdu_q != 32'hFFFF_FFFF) begin
            perf_mdu_q <= perf_mdu_q + 32'd1;
         end
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_mdu_cnt   = perf_mdu_q;
`endif

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb/tb_decode_ctrl_pipe.sv - scoreboard bench for decode_ctrl_pipe with directed instruction vectors
module tb_decode_ctrl_pipe;

   typedef struct packed {
      logic       reg_write, mem_write, mem_read, branch, jump, jump_reg;
      logic       alu_sel, alu_src_a, is_mdu, illegal;
      logic [1:0] result_sel;
      logic [3:0] alu_ctrl;
      logic [2:0] imm_sel;
      logic [2:0] funct3;
      logic [4:0] rs1, rs2, rd;
   } ctl_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] Instr;
   logic        in_valid, in_ready, flush, ex_mem_read;
   logic [4:0]  ex_rd;
   logic        out_valid, out_ready;
   logic        RegWrite, MemWrite, MemRead, Branch, Jump, JumpReg;
   logic        ALUSel, ALUSrcA, IsMDU, illegal;
   logic [1:0]  ResultSel;
   logic [3:0]  ALUCtrl;
   logic [2:0]  ImmSel, funct3_o;
   logic [4:0]  rs1, rs2, rd;
   logic        mdu_start;
`ifdef DECODE_CTRL_PERF_EN
   logic [31:0] perf_stall_cnt, perf_mdu_cnt;
`endif

   int   checks   = 0;
   int   failures = 0;
   ctl_t exp_q[$];

   decode_ctrl_pipe #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .MDU_LATENCY(4)) dut (
      .clk(clk), .rst(rst), .Instr(Instr), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead), .Branch(Branch),
      .Jump(Jump), .JumpReg(JumpReg), .ALUSel(ALUSel), .ALUSrcA(ALUSrcA),
      .IsMDU(IsMDU), .illegal(illegal), .ResultSel(ResultSel), .ALUCtrl(ALUCtrl),
      .ImmSel(ImmSel), .funct3_o(funct3_o), .rs1(rs1), .rs2(rs2), .rd(rd),
      .mdu_start(mdu_start)
`ifdef DECODE_CTRL_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_mdu_cnt(perf_mdu_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // flags = {RW, MW, MR, BR, J, JR, ALUSel, ALUSrcA, IsMDU, illegal}
   function automatic ctl_t mk(input logic [9:0] flags, input logic [1:0] rsel, input logic [3:0] actl,
                               input logic [2:0] isel, input logic [2:0] f3,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdst);
      ctl_t c;
      c = {flags, rsel, actl, isel, f3, r1, r2, rdst};
      return c;
   endfunction

   // drive one instruction, wait (bounded) for acceptance, push its expected decode
   task automatic issue(input logic [31:0] ins, input ctl_t e, output int stalls);
      bit ok;
      ok     = 1'b0;
      stalls = 0;
      Instr    = ins;
      in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         stalls++;
      end
      if (ok) exp_q.push_back(e);
      else chk(1'b0, "accept_timeout", 64'(ins), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // monitor: compare each newly presented output, then require it to hold while stalled
   initial begin
      ctl_t cur, snap, e;
      bit   last_valid, last_hs, fresh;
      last_valid = 1'b0;
      last_hs    = 1'b0;
      snap       = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_valid = 1'b0;
            last_hs    = 1'b0;
         end else begin
            cur = {RegWrite, MemWrite, MemRead, Branch, Jump, JumpReg, ALUSel, ALUSrcA,
                   IsMDU, illegal, ResultSel, ALUCtrl, ImmSel, funct3_o, rs1, rs2, rd};
            fresh = out_valid && (!last_valid || last_hs);
            if (fresh) begin
               if (exp_q.size() == 0) begin
                  chk(1'b0, "unexpected_output", 64'(cur), 64'(0));
               end else begin
                  e = exp_q.pop_front();
                  chk(cur == e, "decode", 64'(cur), 64'(e));
                  chk(mdu_start == e.is_mdu, "mdu_start_pulse", 64'(mdu_start), 64'(e.is_mdu));
               end
               snap = cur;
            end else if (out_valid) begin
               chk(cur == snap, "hold_stable", 64'(cur), 64'(snap));
               chk(mdu_start == 1'b0, "mdu_start_single", 64'(mdu_start), 64'(0));
            end
            last_valid = out_valid;
            last_hs    = out_valid && out_ready;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      int st;
      rst = 1'b1; Instr = '0; in_valid = 1'b0; flush = 1'b0;
      ex_mem_read = 1'b0; ex_rd = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'(0));
      chk(mdu_start == 1'b0, "rst_mdu_start", 64'(mdu_start), 64'(0));
      chk(RegWrite == 1'b0 && ALUCtrl == 4'd0 && rd == 5'd0, "rst_ctrl",
          64'({RegWrite, ALUCtrl, rd}), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;

      issue(32'h00500093, mk(10'b1000001000, 2'b00, 4'b0000, 3'b000, 3'd0, 5'd0, 5'd5, 5'd1), st);
      issue(32'h40208133, mk(10'b1000000000, 2'b00, 4'b1000, 3'b000, 3'd0, 5'd1, 5'd2, 5'd2), st);
      issue(32'h40105093, mk(10'b1000001000, 2'b00, 4'b1101, 3'b000, 3'd5, 5'd0, 5'd1, 5'd1), st);

      // load-use on rs1, then on rs2
      Instr = 32'h002081B3; in_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd1;
      @(negedge clk);
      chk(in_ready == 1'b0, "luse_rs1", 64'(in_ready), 64'(0));
      @(posedge clk); #1; ex_rd = 5'd2;
      @(negedge clk);
      chk(in_ready == 1'b0, "luse_rs2", 64'(in_ready), 64'(0));
      @(posedge clk); #1; ex_mem_read = 1'b0;
      issue(32'h002081B3, mk(10'b1000000000, 2'b00, 4'b0000, 3'b000, 3'd0, 5'd1, 5'd2, 5'd3), st);
      chk(st == 0, "luse_release", 64'(st), 64'(0));

      issue(32'h022081B3, mk(10'b1000000010, 2'b00, 4'b1000, 3'b000, 3'd0, 5'd1, 5'd2, 5'd3), st);
      issue(32'h00500093, mk(10'b1000001000, 2'b00, 4'b0000, 3'b000, 3'd0, 5'd0, 5'd5, 5'd1), st);
      chk(st == 3, "mdu_stall_cycles", 64'(st), 64'(3));

      // LUI does not read rs1 even though bits [19:15] match the load destination
      ex_mem_read = 1'b1; ex_rd = 5'd8;
      issue(32'h123452B7, mk(10'b1000000000, 2'b10, 4'b0000, 3'b011, 3'd5, 5'd8, 5'd3, 5'd5), st);
      chk(st == 0, "lui_no_luse", 64'(st), 64'(0));
      ex_rd = 5'd0;
      issue(32'h00000013, mk(10'b0000001000, 2'b00, 4'b0000, 3'b000, 3'd0, 5'd0, 5'd0, 5'd0), st);
      chk(st == 0, "ex_rd_zero_no_luse", 64'(st), 64'(0));
      ex_mem_read = 1'b0;

      // backpressure hold, then flush discards held and pending instruction
      issue(32'h00812283, mk(10'b1010001000, 2'b01, 4'b0000, 3'b000, 3'd2, 5'd2, 5'd8, 5'd5), st);
      out_ready = 1'b0;
      Instr = 32'h00512623; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk(in_ready == 1'b0 && out_valid == 1'b1, "stall_ready_low",
             64'({out_valid, in_ready}), 64'(2));
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(negedge clk);
      chk(in_ready == 1'b0, "flush_ready_low", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk(out_valid == 1'b0, "flush_out_valid", 64'(out_valid), 64'(0));
      @(posedge clk); #1;
      out_ready = 1'b1;

      issue(32'h00512623, mk(10'b0100001000, 2'b00, 4'b0000, 3'b001, 3'd2, 5'd2, 5'd5, 5'd12), st);
      issue(32'h00208463, mk(10'b0001000000, 2'b00, 4'b1000, 3'b010, 3'd0, 5'd1, 5'd2, 5'd8), st);
      issue(32'h010000EF, mk(10'b1000100000, 2'b11, 4'b0000, 3'b100, 3'd0, 5'd0, 5'd16, 5'd1), st);
      issue(32'h00001317, mk(10'b1000001100, 2'b00, 4'b0000, 3'b011, 3'd1, 5'd0, 5'd0, 5'd6), st);
      issue(32'h00008067, mk(10'b0000011000, 2'b11, 4'b0000, 3'b000, 3'd0, 5'd1, 5'd0, 5'd0), st);
      issue(32'h04208133, mk(10'b0000000001, 2'b00, 4'b0000, 3'b000, 3'd0, 5'd1, 5'd2, 5'd2), st);
      issue(32'hFFFFFFFF, mk(10'b0000000001, 2'b00, 4'b0000, 3'b000, 3'd7, 5'd31, 5'd31, 5'd31), st);

      repeat (4) @(posedge clk);
      @(negedge clk);
      chk(exp_q.size() == 0, "scoreboard_drained", 64'(exp_q.size()), 64'(0));
      chk(out_valid == 1'b0, "idle_out_valid", 64'(out_valid), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
